// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state/pc_sel encodings and saturating increment for pipeline_ctrl
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] PCSEL_SEQ  = 2'd0;
  localparam logic [1:0] PCSEL_BR   = 2'd1;
  localparam logic [1:0] PCSEL_JAL  = 2'd2;
  localparam logic [1:0] PCSEL_JALR = 2'd3;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - consecutive data-memory wait counter with timeout compare
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Parks at LIMIT so a stuck enable can never wrap back below the timeout.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard/sequencing controller: load-use bubbles, redirects, memory waits
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_jal,
  input  logic             mem_jalr,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             id_ex_hold,
  output logic             ex_mem_hold,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_flush,
  output logic [1:0]       pc_sel,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;
  logic             mem_err_q, mem_err_d;

  logic redirect, load_use, expired;
  logic tmr_clr, tmr_en;
  logic eval_hazards, stall_inc, flush_inc;

  assign redirect = mem_jal | mem_jalr | (mem_branch & mem_zero);
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  always_comb begin
    state_d      = state_q;
    mem_err_d    = mem_err_q;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    id_ex_hold   = 1'b0;
    ex_mem_hold  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_flush     = 1'b0;
    pc_sel       = PCSEL_SEQ;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    eval_hazards = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    if (state_q == ST_RUN) begin
      if (mem_req && !mem_ready) begin
        {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold} = 4'b1111;
        tmr_en  = 1'b1;
        state_d = ST_MEM_WAIT;
      end else begin
        eval_hazards = 1'b1;
      end
    end else begin
      // Every MEM_WAIT cycle counts as a stall, including the exit cycle.
      stall_inc = 1'b1;
      if (mem_ready || expired) begin
        eval_hazards = 1'b1;
        tmr_clr      = 1'b1;
        state_d      = ST_RUN;
        if (!mem_ready) begin
          mem_err_d = 1'b1;
        end
      end else begin
        {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold} = 4'b1111;
        tmr_en = 1'b1;
      end
    end

    if (eval_hazards) begin
      if (redirect) begin
        if (mem_jalr) begin
          pc_sel = PCSEL_JALR;
        end else if (mem_jal) begin
          pc_sel = PCSEL_JAL;
        end else begin
          pc_sel = PCSEL_BR;
        end
        {if_id_flush, id_ex_flush, ex_flush} = 3'b111;
        flush_inc = 1'b1;
      end else if (load_use) begin
        pc_hold     = 1'b1;
        if_id_hold  = 1'b1;
        id_ex_flush = 1'b1;
        stall_inc   = 1'b1;
      end
    end

    // Controls are forced quiet for as long as reset is held.
    if (reset) begin
      {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold} = 4'b0000;
      {if_id_flush, id_ex_flush, ex_flush}           = 3'b000;
      pc_sel                                         = PCSEL_SEQ;
    end

    stall_cycles_d = stall_inc ? CNT_W'(sat_inc(32'(stall_cycles_q), CNT_MAX)) : stall_cycles_q;
    flush_events_d = flush_inc ? CNT_W'(sat_inc(32'(flush_events_q), CNT_MAX)) : flush_events_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RUN;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
      mem_err_q      <= mem_err_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
  assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2, ex_mem_read;
  logic             mem_branch, mem_zero, mem_jal, mem_jalr, mem_req, mem_ready;
  logic             pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
  logic             if_id_flush, id_ex_flush, ex_flush;
  logic [1:0]       pc_sel;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] C_NONE  = 9'b0000_000_00;
  localparam logic [8:0] C_HOLD4 = 9'b1111_000_00;
  localparam logic [8:0] C_LU    = 9'b1100_010_00;
  localparam logic [8:0] C_BR    = 9'b0000_111_01;
  localparam logic [8:0] C_JAL   = 9'b0000_111_10;
  localparam logic [8:0] C_JALR  = 9'b0000_111_11;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .mem_branch   (mem_branch),
    .mem_zero     (mem_zero),
    .mem_jal      (mem_jal),
    .mem_jalr     (mem_jalr),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_hold      (pc_hold),
    .if_id_hold   (if_id_hold),
    .id_ex_hold   (id_ex_hold),
    .ex_mem_hold  (ex_mem_hold),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_flush     (ex_flush),
    .pc_sel       (pc_sel),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ctl();
    return {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush, ex_flush, pc_sel};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    mem_branch = 1'b0; mem_zero = 1'b0; mem_jal = 1'b0; mem_jalr = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic load_use_in(input logic [4:0] rd, input logic use2);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = 5'd5; id_uses_rs2 = use2;
  endtask

  // Inputs change 1ns after the rising edge; checks run 1ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    mem_jal = 1'b1;
    #2;
    chk("reset_ctl_gated", 32'(ctl()), 32'(C_NONE));
    chk("reset_stall", 32'(stall_cycles), 0);
    chk("reset_flush", 32'(flush_events), 0);
    chk("reset_err", 32'(mem_err), 0);
    cyc();
    reset = 1'b0;
    clear_in();
    #1 chk("idle", 32'(ctl()), 32'(C_NONE));

    cyc(); load_use_in(5'd5, 1'b1);
    #1 chk("lu_rs2", 32'(ctl()), 32'(C_LU));
    cyc(); clear_in();
    #1 chk("lu_one_bubble", 32'(ctl()), 32'(C_NONE));
    chk("lu_stall1", 32'(stall_cycles), 1);
    cyc(); load_use_in(5'd0, 1'b1);
    #1 chk("lu_rd_zero", 32'(ctl()), 32'(C_NONE));
    cyc(); load_use_in(5'd5, 1'b0);
    #1 chk("lu_no_use", 32'(ctl()), 32'(C_NONE));
    cyc(); clear_in(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
    #1 chk("lu_rs1", 32'(ctl()), 32'(C_LU));
    cyc(); clear_in();
    #1 chk("lu_stall2", 32'(stall_cycles), 2);

    mem_branch = 1'b1; mem_zero = 1'b1;
    #1 chk("branch_taken", 32'(ctl()), 32'(C_BR));
    cyc(); clear_in(); mem_branch = 1'b1;
    #1 chk("branch_not_taken", 32'(ctl()), 32'(C_NONE));
    chk("flush1", 32'(flush_events), 1);
    cyc(); clear_in(); mem_jal = 1'b1; mem_jalr = 1'b1;
    #1 chk("jalr_over_jal", 32'(ctl()), 32'(C_JALR));
    cyc(); clear_in(); mem_jal = 1'b1; load_use_in(5'd5, 1'b1);
    #1 chk("jal_over_lu", 32'(ctl()), 32'(C_JAL));
    cyc(); clear_in();
    #1 chk("flush3", 32'(flush_events), 3);
    chk("stall_unchanged", 32'(stall_cycles), 2);

    do_reset();
    mem_req = 1'b1; mem_jal = 1'b1;
    #1 chk("wait_c0", 32'(ctl()), 32'(C_HOLD4));
    cyc();
    #1 chk("wait_c1", 32'(ctl()), 32'(C_HOLD4));
    cyc();
    #1 chk("wait_c2", 32'(ctl()), 32'(C_HOLD4));
    cyc(); mem_ready = 1'b1;
    #1 chk("wait_ready_jal", 32'(ctl()), 32'(C_JAL));
    cyc(); clear_in();
    #1 chk("wait_back_run", 32'(ctl()), 32'(C_NONE));
    chk("wait_stall3", 32'(stall_cycles), 3);
    chk("wait_flush1", 32'(flush_events), 1);
    chk("wait_no_err", 32'(mem_err), 0);
    mem_req = 1'b1; mem_ready = 1'b1; load_use_in(5'd5, 1'b1);
    #1 chk("req_ready_same", 32'(ctl()), 32'(C_LU));
    cyc(); clear_in();
    #1 chk("req_ready_stall4", 32'(stall_cycles), 4);

    mem_req = 1'b1;
    #1 chk("to_c0", 32'(ctl()), 32'(C_HOLD4));
    for (int i = 1; i <= 3; i++) begin
      cyc();
      #1 chk($sformatf("to_c%0d", i), 32'(ctl()), 32'(C_HOLD4));
    end
    cyc();
    #1 chk("to_exit", 32'(ctl()), 32'(C_NONE));
    chk("to_err_not_yet", 32'(mem_err), 0);
    cyc(); clear_in();
    #1 chk("to_err_set", 32'(mem_err), 1);
    chk("to_stall8", 32'(stall_cycles), 8);
    chk("to_run_after", 32'(ctl()), 32'(C_NONE));
    cyc();
    #1 chk("to_err_sticky", 32'(mem_err), 1);

    mem_req = 1'b1;
    cyc();
    #1 chk("rst_mw_hold", 32'(ctl()), 32'(C_HOLD4));
    reset = 1'b1;
    #1 chk("rst_async_ctl", 32'(ctl()), 32'(C_NONE));
    chk("rst_async_stall", 32'(stall_cycles), 0);
    chk("rst_async_flush", 32'(flush_events), 0);
    chk("rst_async_err", 32'(mem_err), 0);
    cyc();
    reset = 1'b0; clear_in(); load_use_in(5'd5, 1'b1);
    #1 chk("rst_back_run", 32'(ctl()), 32'(C_LU));

    for (int i = 0; i < 19; i++) cyc();
    cyc(); clear_in();
    #1 chk("stall_saturate", 32'(stall_cycles), 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
